// File: rtl/branch_update_tracker.sv
// Tracks dispatched conditional branches in program order and, once each is resolved and
// committed, emits in-order direction updates to the fetch-stage branch predictor.
module branch_update_tracker #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 4,
  parameter int FETCHID_W = 4,
  parameter int OFFS_W    = 3,
  parameter int TAG_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IN_alloc_valid,
  input  logic [FETCHID_W-1:0] IN_alloc_fetchID,
  input  logic [OFFS_W-1:0]    IN_alloc_offs,
  input  logic [TAG_W-1:0]     IN_alloc_tag,
  output logic [IDX_W-1:0]     OUT_alloc_idx,
  output logic                 OUT_full,
  input  logic                 IN_res_valid,
  input  logic [IDX_W-1:0]     IN_res_idx,
  input  logic                 IN_res_taken,
  input  logic [TAG_W-1:0]     IN_comSqN,
  input  logic                 IN_flush_valid,
  input  logic [TAG_W-1:0]     IN_flush_tag,
  output logic                 OUT_upd_valid,
  output logic [FETCHID_W-1:0] OUT_upd_fetchID,
  output logic [OFFS_W-1:0]    OUT_upd_offs,
  output logic                 OUT_upd_taken,
  input  logic                 IN_upd_ready,
  output logic [IDX_W:0]       OUT_count
);

  logic [IDX_W:0]          r_head;
  logic [IDX_W:0]          r_tail;
  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH-1:0]        r_resolved;
  logic [DEPTH-1:0]        r_taken;
  logic [FETCHID_W-1:0]    r_fid  [DEPTH];
  logic [OFFS_W-1:0]       r_offs [DEPTH];
  logic [TAG_W-1:0]        r_tag  [DEPTH];

  logic                    r_upd_vld_p1;
  logic [FETCHID_W-1:0]    r_upd_fid_p1;
  logic [OFFS_W-1:0]       r_upd_offs_p1;
  logic                    r_upd_taken_p1;

  logic [IDX_W:0]          w_count;
  logic                    w_full;
  logic [IDX_W-1:0]        w_hidx;
  logic [IDX_W-1:0]        w_tidx;
  logic [IDX_W-1:0]        w_off [DEPTH];
  logic [DEPTH-1:0]        w_inflight;
  logic [DEPTH-1:0]        w_kill;
  logic                    w_flush_hit;
  logic [IDX_W-1:0]        w_flush_off;
  logic [IDX_W:0]          w_new_tail;
  logic                    w_emit;
  logic                    w_alloc;
  logic                    w_res_ok;

  // Wrapping tag order: a is older than b when the TAG_W-bit difference is negative.
  function automatic logic tag_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return d[TAG_W-1];
  endfunction

  function automatic logic tag_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return !d[TAG_W-1] && (d != '0);
  endfunction

  assign w_count       = r_tail - r_head;
  assign w_full        = (w_count == (IDX_W+1)'(DEPTH));
  assign w_hidx        = r_head[IDX_W-1:0];
  assign w_tidx        = r_tail[IDX_W-1:0];
  assign OUT_alloc_idx = w_tidx;
  assign OUT_full      = w_full;
  assign OUT_count     = w_count;

  // Program-order distance of each slot from head; slots below count are in flight.
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    assign w_off[j]      = IDX_W'(j) - w_hidx;
    assign w_inflight[j] = ({1'b0, w_off[j]} < w_count);
    assign w_kill[j]     = IN_flush_valid && w_flush_hit && w_inflight[j] &&
                           (w_off[j] >= w_flush_off);
  end

  always_comb begin
    w_flush_hit = 1'b0;
    w_flush_off = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (r_valid[j] && w_inflight[j] && tag_younger(r_tag[j], IN_flush_tag) &&
          (!w_flush_hit || (w_off[j] < w_flush_off))) begin
        w_flush_hit = 1'b1;
        w_flush_off = w_off[j];
      end
    end
  end

  assign w_new_tail = r_head + {1'b0, w_flush_off};
  assign w_alloc    = IN_alloc_valid && !w_full && !IN_flush_valid;
  assign w_res_ok   = IN_res_valid && r_valid[IN_res_idx] && !w_kill[IN_res_idx];
  assign w_emit     = r_valid[w_hidx] && r_resolved[w_hidx] && !w_kill[w_hidx] &&
                      tag_older(r_tag[w_hidx], IN_comSqN) &&
                      (!r_upd_vld_p1 || IN_upd_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_valid      <= '0;
      r_resolved   <= '0;
      r_upd_vld_p1 <= 1'b0;
    end else begin
      if (IN_flush_valid && w_flush_hit)
        r_tail <= w_new_tail;
      else if (w_alloc)
        r_tail <= r_tail + 1'b1;
      if (w_emit)
        r_head <= r_head + 1'b1;
      for (int j = 0; j < DEPTH; j++)
        if (w_kill[j]) r_valid[j] <= 1'b0;
      if (w_emit)
        r_valid[w_hidx] <= 1'b0;
      if (w_alloc) begin
        r_valid[w_tidx]    <= 1'b1;
        r_resolved[w_tidx] <= 1'b0;
      end
      if (w_res_ok)
        r_resolved[IN_res_idx] <= 1'b1;
      if (w_emit)
        r_upd_vld_p1 <= 1'b1;
      else if (IN_upd_ready)
        r_upd_vld_p1 <= 1'b0;
    end
  end

  // Stage p1: entry payload and the registered update toward the predictor.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_fid[w_tidx]  <= IN_alloc_fetchID;
      r_offs[w_tidx] <= IN_alloc_offs;
      r_tag[w_tidx]  <= IN_alloc_tag;
    end
    if (w_res_ok)
      r_taken[IN_res_idx] <= IN_res_taken;
    if (w_emit) begin
      r_upd_fid_p1   <= r_fid[w_hidx];
      r_upd_offs_p1  <= r_offs[w_hidx];
      r_upd_taken_p1 <= r_taken[w_hidx];
    end
  end

  assign OUT_upd_valid   = r_upd_vld_p1;
  assign OUT_upd_fetchID = r_upd_fid_p1;
  assign OUT_upd_offs    = r_upd_offs_p1;
  assign OUT_upd_taken   = r_upd_taken_p1;

endmodule

// File: tb/tb_branch_update_tracker.sv
// Directed scenarios followed by randomized traffic for branch_update_tracker, checked
// against a program-order queue model of the tracked branches.
module tb_branch_update_tracker;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       alloc_valid;
  logic [3:0] alloc_fid;
  logic [2:0] alloc_offs;
  logic [6:0] alloc_tag;
  logic [3:0] alloc_idx;
  logic       full;
  logic       res_valid;
  logic [3:0] res_idx;
  logic       res_taken;
  logic [6:0] com;
  logic       flush_valid;
  logic [6:0] flush_tag;
  logic       upd_valid;
  logic [3:0] upd_fid;
  logic [2:0] upd_offs;
  logic       upd_taken;
  logic       ready;
  logic [4:0] count;

  branch_update_tracker dut (
    .clk(clk), .rst(rst),
    .IN_alloc_valid(alloc_valid), .IN_alloc_fetchID(alloc_fid), .IN_alloc_offs(alloc_offs),
    .IN_alloc_tag(alloc_tag), .OUT_alloc_idx(alloc_idx), .OUT_full(full),
    .IN_res_valid(res_valid), .IN_res_idx(res_idx), .IN_res_taken(res_taken),
    .IN_comSqN(com), .IN_flush_valid(flush_valid), .IN_flush_tag(flush_tag),
    .OUT_upd_valid(upd_valid), .OUT_upd_fetchID(upd_fid), .OUT_upd_offs(upd_offs),
    .OUT_upd_taken(upd_taken), .IN_upd_ready(ready), .OUT_count(count)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [6:0] tag;
    logic [3:0] fid;
    logic [2:0] offs;
    bit         res;
    bit         tk;
  } ent_t;

  ent_t       q[$];
  int         m_hidx;
  bit         m_ov;
  logic [3:0] m_ofid;
  logic [2:0] m_ooffs;
  bit         m_otk;
  bit         m_acc;

  function automatic bit older(input logic [6:0] a, input logic [6:0] b);
    logic signed [6:0] d;
    d = a - b;
    return d < 0;
  endfunction

  function automatic bit younger(input logic [6:0] a, input logic [6:0] b);
    logic signed [6:0] d;
    d = a - b;
    return d > 0;
  endfunction

  function automatic int tidx();
    return (m_hidx + q.size()) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int   fpos;
    int   keep;
    int   tpos;
    bit   pre_full;
    bit   emit;
    ent_t e;
    m_acc = 1'b0;
    if (rst) begin
      q.delete();
      m_hidx = 0;
      m_ov   = 1'b0;
      return;
    end
    fpos = -1;
    if (flush_valid)
      for (int i = 0; i < q.size(); i++)
        if (fpos < 0 && younger(q[i].tag, flush_tag)) fpos = i;
    keep     = (fpos < 0) ? q.size() : fpos;
    pre_full = (q.size() == DEPTH);
    tpos     = tidx();
    emit     = (keep > 0) && q[0].res && older(q[0].tag, com) && (!m_ov || ready);
    if (emit) e = q[0];
    if (res_valid)
      for (int i = 0; i < keep; i++)
        if (q[i].idx == int'(res_idx)) begin
          q[i].res = 1'b1;
          q[i].tk  = res_taken;
        end
    while (q.size() > keep) void'(q.pop_back());
    if (emit) begin
      void'(q.pop_front());
      m_hidx  = (m_hidx + 1) % DEPTH;
      m_ov    = 1'b1;
      m_ofid  = e.fid;
      m_ooffs = e.offs;
      m_otk   = e.tk;
    end else if (ready) begin
      m_ov = 1'b0;
    end
    if (alloc_valid && !pre_full && !flush_valid) begin
      q.push_back('{tpos, alloc_tag, alloc_fid, alloc_offs, 1'b0, 1'b0});
      m_acc = 1'b1;
    end
  endtask

  task automatic cyc();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("alloc_idx", 32'(alloc_idx), 32'(tidx()));
    chk("upd_valid", 32'(upd_valid), 32'(m_ov));
    if (m_ov) begin
      chk("upd_fid", 32'(upd_fid), 32'(m_ofid));
      chk("upd_offs", 32'(upd_offs), 32'(m_ooffs));
      chk("upd_taken", 32'(upd_taken), 32'(m_otk));
    end
    model_step();
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    res_valid   = 1'b0;
    flush_valid = 1'b0;
  endtask

  task automatic do_alloc(input int t, input int f, input int o);
    alloc_valid = 1'b1;
    alloc_tag   = 7'(t);
    alloc_fid   = 4'(f);
    alloc_offs  = 3'(o);
    cyc();
  endtask

  task automatic do_res(input int i, input bit tk);
    res_valid = 1'b1;
    res_idx   = 4'(i % DEPTH);
    res_taken = tk;
    cyc();
  endtask

  initial begin
    int t0;
    int nt;
    int cm;
    int ft;
    int k;
    bit fl;
    rst = 1'b1; alloc_valid = 1'b0; alloc_fid = '0; alloc_offs = '0; alloc_tag = '0;
    res_valid = 1'b0; res_idx = '0; res_taken = 1'b0; com = '0;
    flush_valid = 1'b0; flush_tag = '0; ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); m_hidx = 0; m_ov = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_alloc_idx", 32'(alloc_idx), 0);

    // In-order basic
    do_alloc(5, 2, 1);
    do_alloc(6, 3, 4);
    do_res(0, 1'b1);
    do_res(1, 1'b0);
    com = 7'd7;
    cyc();
    chk("s1_u0_valid", 32'(upd_valid), 1);
    chk("s1_u0_fid", 32'(upd_fid), 2);
    chk("s1_u0_offs", 32'(upd_offs), 1);
    chk("s1_u0_taken", 32'(upd_taken), 1);
    cyc();
    chk("s1_u1_fid", 32'(upd_fid), 3);
    chk("s1_u1_offs", 32'(upd_offs), 4);
    chk("s1_u1_taken", 32'(upd_taken), 0);
    cyc();
    chk("s1_count_end", 32'(count), 0);
    chk("s1_valid_end", 32'(upd_valid), 0);

    // Out-of-order resolve
    com = 7'd20;
    t0 = tidx();
    do_alloc(8, 1, 0);
    do_alloc(9, 2, 1);
    do_alloc(10, 3, 2);
    do_res(t0 + 2, 1'b1);
    cyc();
    chk("s2_wait", 32'(upd_valid), 0);
    do_res(t0, 1'b0);
    chk("s2_wait2", 32'(upd_valid), 0);
    do_res(t0 + 1, 1'b1);
    chk("s2_first", 32'(upd_fid), 1);
    cyc();
    chk("s2_second", 32'(upd_fid), 2);
    cyc();
    chk("s2_third", 32'(upd_fid), 3);
    repeat (2) cyc();

    // Commit gating
    com = 7'd10;
    t0 = tidx();
    do_alloc(10, 7, 5);
    do_res(t0, 1'b1);
    repeat (2) cyc();
    chk("s3_gated", 32'(upd_valid), 0);
    com = 7'd11;
    cyc();
    chk("s3_emit", 32'(upd_valid), 1);
    chk("s3_fid", 32'(upd_fid), 7);
    cyc();

    // Flush with a same-cycle resolve of a flushed entry
    com = 7'd20;
    t0 = tidx();
    for (int i = 0; i < 5; i++) do_alloc(20 + i, 8 + i, i);
    flush_valid = 1'b1; flush_tag = 7'd21;
    res_valid = 1'b1; res_idx = 4'((t0 + 3) % DEPTH); res_taken = 1'b1;
    cyc();
    chk("s4_count", 32'(count), 2);
    chk("s4_alloc_idx", 32'(alloc_idx), 32'((t0 + 2) % DEPTH));
    do_res(t0, 1'b1);
    do_res(t0 + 1, 1'b0);
    com = 7'd30;
    repeat (4) cyc();
    do_alloc(25, 1, 1);
    repeat (3) cyc();
    chk("s4_realloc_unres", 32'(upd_valid), 0);
    do_res(t0 + 2, 1'b0);
    repeat (3) cyc();

    // Full, drop, wrap of index and tag
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    com = 7'd120;
    for (int i = 0; i < 16; i++) do_alloc(120 + i, i, i);
    chk("s5_full", 32'(full), 1);
    chk("s5_count16", 32'(count), 16);
    do_alloc(8, 15, 7);
    chk("s5_drop", 32'(count), 16);
    do_res(0, 1'b1);
    com = 7'd121;
    cyc();
    chk("s5_wrap_idx", 32'(alloc_idx), 0);
    chk("s5_notfull", 32'(full), 0);
    do_alloc(8, 9, 1);
    for (int i = 1; i <= 16; i++) do_res(i, 1'(i));
    com = 7'd1;
    repeat (10) cyc();
    chk("s5_tagwrap_left", 32'(count), 8);
    com = 7'd9;
    repeat (12) cyc();
    chk("s5_drained", 32'(count), 0);

    // Backpressure
    com = 7'd50;
    ready = 1'b0;
    t0 = tidx();
    do_alloc(50, 5, 2);
    do_alloc(51, 6, 3);
    do_res(t0, 1'b1);
    do_res(t0 + 1, 1'b0);
    com = 7'd52;
    cyc();
    repeat (3) begin
      chk("s6_hold_valid", 32'(upd_valid), 1);
      chk("s6_hold_fid", 32'(upd_fid), 5);
      chk("s6_hold_offs", 32'(upd_offs), 2);
      chk("s6_hold_count", 32'(count), 1);
      cyc();
    end
    ready = 1'b1;
    cyc();
    chk("s6_second_fid", 32'(upd_fid), 6);
    chk("s6_second_taken", 32'(upd_taken), 0);
    cyc();
    chk("s6_drained", 32'(upd_valid), 0);

    // Randomized traffic
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    nt = 0;
    cm = 0;
    for (int n = 0; n < 3000; n++) begin
      ready = ($urandom % 4) != 0;
      if (($urandom % 4) == 0 && cm < nt) cm++;
      com = 7'(cm);
      alloc_valid = (($urandom % 3) != 0) && ((nt - cm) < 40);
      alloc_tag   = 7'(nt);
      alloc_fid   = 4'($urandom);
      alloc_offs  = 3'($urandom);
      res_valid   = 1'($urandom);
      res_taken   = 1'($urandom);
      if (q.size() > 0 && ($urandom % 4) != 0) begin
        k = int'($urandom_range(0, q.size() - 1));
        res_idx = 4'(q[k].idx);
      end else begin
        res_idx = 4'($urandom);
      end
      fl = ($urandom % 40) == 0;
      ft = 0;
      if (fl) ft = cm - 1 + int'($urandom_range(0, nt - cm));
      flush_valid = fl;
      flush_tag   = 7'(ft);
      rst = ($urandom % 700) == 0;
      cyc();
      rst = 1'b0;
      if (fl) nt = ft + 1;
      else if (m_acc) nt++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
